// File: rtl/fetch_buffer.sv
// Instruction fetch decoupling stage between the core fetch port and the TCM.
// Credit-limits fetch issue, buffers responses in order, and discards stale responses after a flush.
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_rd_i,
  input  logic [31:0] core_pc_i,
  input  logic        core_flush_i,
  input  logic        core_invalidate_i,
  input  logic        core_ready_i,
  output logic        core_accept_o,
  output logic        core_valid_o,
  output logic        core_error_o,
  output logic [31:0] core_inst_o,
  output logic        mem_rd_o,
  output logic [31:0] mem_pc_o,
  output logic        mem_flush_o,
  output logic        mem_invalidate_o,
  input  logic        mem_accept_i,
  input  logic        mem_valid_i,
  input  logic        mem_error_i,
  input  logic [31:0] mem_inst_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SUM_W = CNT_W + 2;

  logic [32:0]      fifo_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_s, wr_ptr_s;
  logic [CNT_W-1:0] fifo_cnt_r, outstanding_r, discard_r;
  logic [CNT_W-1:0] fifo_cnt_s, outstanding_s, discard_s;
  logic             core_valid_r, core_error_r;
  logic [31:0]      core_inst_r;
  logic [SUM_W-1:0] inflight_s;
  logic             credit_s, issue_s, drop_s, push_s, pop_s, valid_s;
  logic [32:0]      head_s;

  assign inflight_s = {2'b00, outstanding_r} + {2'b00, fifo_cnt_r} + {2'b00, discard_r};
  assign credit_s   = inflight_s < SUM_W'(DEPTH);
  assign mem_rd_o   = core_rd_i & credit_s & ~core_flush_i;
  assign issue_s    = mem_rd_o & mem_accept_i;
  assign drop_s     = mem_valid_i & (core_flush_i | (discard_r != {CNT_W{1'b0}}));
  assign push_s     = mem_valid_i & ~drop_s;
  assign pop_s      = core_valid_r & core_ready_i & ~core_flush_i;

  assign core_accept_o    = issue_s;
  assign mem_pc_o         = core_pc_i;
  assign mem_flush_o      = core_flush_i;
  assign mem_invalidate_o = core_invalidate_i;
  assign core_valid_o     = core_valid_r;
  assign core_error_o     = core_error_r;
  assign core_inst_o      = core_inst_r;

  // Next-state for pointers, counters and the head word presented next cycle.
  always_comb begin
    rd_ptr_s      = rd_ptr_r + PTR_W'(pop_s);
    wr_ptr_s      = wr_ptr_r + PTR_W'(push_s);
    fifo_cnt_s    = fifo_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
    outstanding_s = outstanding_r + CNT_W'(issue_s) - CNT_W'(push_s);
    discard_s     = discard_r - CNT_W'(drop_s);
    head_s        = fifo_r[rd_ptr_s];
    // A word pushed into the slot that becomes head bypasses the storage read.
    if (push_s && (wr_ptr_r == rd_ptr_s)) begin
      head_s = {mem_error_i, mem_inst_i};
    end else begin
      head_s = fifo_r[rd_ptr_s];
    end
    if (core_flush_i) begin
      rd_ptr_s      = {PTR_W{1'b0}};
      wr_ptr_s      = {PTR_W{1'b0}};
      fifo_cnt_s    = {CNT_W{1'b0}};
      outstanding_s = {CNT_W{1'b0}};
      discard_s     = discard_r + outstanding_r -
                      CNT_W'(mem_valid_i && ((discard_r != {CNT_W{1'b0}}) ||
                                             (outstanding_r != {CNT_W{1'b0}})));
    end else begin
      discard_s     = discard_r - CNT_W'(drop_s);
    end
    valid_s = (fifo_cnt_s != {CNT_W{1'b0}});
  end

  // Response storage; only written on accepted (non-discarded) responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_r[i] <= 33'd0;
      end
    end else if (push_s) begin
      fifo_r[wr_ptr_r] <= {mem_error_i, mem_inst_i};
    end
  end

  // Control state and registered core-facing outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_r      <= {PTR_W{1'b0}};
      wr_ptr_r      <= {PTR_W{1'b0}};
      fifo_cnt_r    <= {CNT_W{1'b0}};
      outstanding_r <= {CNT_W{1'b0}};
      discard_r     <= {CNT_W{1'b0}};
      core_valid_r  <= 1'b0;
      core_error_r  <= 1'b0;
      core_inst_r   <= 32'd0;
    end else begin
      rd_ptr_r      <= rd_ptr_s;
      wr_ptr_r      <= wr_ptr_s;
      fifo_cnt_r    <= fifo_cnt_s;
      outstanding_r <= outstanding_s;
      discard_r     <= discard_s;
      core_valid_r  <= valid_s;
      if (valid_s) begin
        core_error_r <= head_s[32];
        core_inst_r  <= head_s[31:0];
      end else begin
        core_error_r <= 1'b0;
        core_inst_r  <= core_inst_r;
      end
    end
  end

  fetch_buffer_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push          (push_s),
    .pop           (pop_s),
    .fifo_cnt      (fifo_cnt_r),
    .outstanding   (outstanding_r),
    .discard       (discard_r),
    .mem_valid     (mem_valid_i)
  );

endmodule

// Invariant checker: the credit scheme must keep every counter in range.
module fetch_buffer_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clk_i,
  input logic             rst_i,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] fifo_cnt,
  input logic [CNT_W-1:0] outstanding,
  input logic [CNT_W-1:0] discard,
  input logic             mem_valid
);

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> (pop || (fifo_cnt < CNT_W'(DEPTH))));

  a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    ({2'b00, fifo_cnt} + {2'b00, outstanding} + {2'b00, discard}) <= (CNT_W+2)'(DEPTH));

  a_resp_tracked: assert property (@(posedge clk_i) disable iff (rst_i)
    mem_valid |-> ((outstanding != {CNT_W{1'b0}}) || (discard != {CNT_W{1'b0}})));

endmodule
